fp_vec_result_drain: RTL and testbench

Result drain stage directly downstream of the 4-lane FP vector adder (FP12 by default: 1 sign, 5 exponent, 6 mantissa bits). The adder has no backpressure. This block therefore captures every result vector into a small FIFO and serialises the lanes a, b, c, d onto a single valid/ready stream. It also issues credits to the upstream issuer so the adder is never launched without a guaranteed FIFO slot.

---
 rtl/fp_vec_result_drain.sv | 124 ++++++++++++
 tb/tb_fp_vec_result_drain.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_vec_result_drain.sv
// Result drain behind the 4-lane FP vector adder: captures whole result vectors into a
// small FIFO, serialises lanes a..d onto one valid/ready stream and issues launch credits.

module fp_vec_lane_store #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  // Payload only; validity is tracked by the FIFO count, so no reset is needed here.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

module fp_vec_result_drain #(
  parameter int EXP_BITS  = 5,
  parameter int MANT_BITS = 6,
  parameter int DEPTH     = 4,
  localparam int W        = 1 + EXP_BITS + MANT_BITS,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  output logic          issue_ok,
  input  logic          in_valid,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  input  logic [W-1:0]  c_in,
  input  logic [W-1:0]  d_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [1:0]    out_lane,
  output logic          out_last,
  output logic [CW-1:0] occupancy,
  output logic          overflow
);
  localparam int NUM_LANES = 4;
  localparam int PW        = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW:0]   FULL_EXT = (CW+1)'(DEPTH);

  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic [CW-1:0] pending, pending_nxt;
  logic [1:0]    lane_cnt;

  logic [NUM_LANES-1:0][W-1:0] wr_vec, rd_vec;
  logic pop, wr_en, drop, issue_acc, issue_bad;
  logic [CW:0] credit_sum;

  assign wr_vec = {d_in, c_in, b_in, a_in};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fp_vec_lane_store #(.W(W), .DEPTH(DEPTH), .PW(PW)) u_store (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wptr),
      .wdata (wr_vec[g]),
      .raddr (rptr),
      .rdata (rd_vec[g])
    );
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? rd_vec[lane_cnt] : '0;
  assign out_lane  = lane_cnt;
  assign out_last  = out_valid & (lane_cnt == 2'd3);
  assign occupancy = count;

  // A pop frees the head slot in the same cycle, so a full FIFO can still take a write.
  assign pop   = out_valid & out_ready & (lane_cnt == 2'd3);
  assign wr_en = in_valid & ((count != FULL) | pop);
  assign drop  = in_valid & ~wr_en;

  // Credit check sees registered state only; a same-cycle pop frees credit next cycle.
  assign credit_sum = {1'b0, count} + {1'b0, pending};
  assign issue_ok   = (credit_sum < FULL_EXT);
  assign issue_acc  = issue & issue_ok;
  assign issue_bad  = issue & ~issue_ok;

  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)      count_nxt = count + 1'b1;
    else if (!wr_en && pop) count_nxt = count - 1'b1;
  end

  // Returns after reset release find pending at 0 and are simply not credited.
  always_comb begin
    pending_nxt = pending;
    if (issue_acc && !in_valid)                        pending_nxt = pending + 1'b1;
    else if (!issue_acc && in_valid && pending != '0)  pending_nxt = pending - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pending  <= '0;
      lane_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      count   <= count_nxt;
      pending <= pending_nxt;
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (out_valid && out_ready) lane_cnt <= lane_cnt + 1'b1;
      if (drop || issue_bad) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_vec_result_drain.sv
// Directed bench for fp_vec_result_drain: streaming, backpressure, credits, full/overflow, async reset.

module tb_fp_vec_result_drain;
  localparam int W = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue, issue_ok, in_valid;
  logic [W-1:0]  a_in, b_in, c_in, d_in;
  logic          out_valid, out_ready, out_last, overflow;
  logic [W-1:0]  out_data;
  logic [1:0]    out_lane;
  logic [2:0]    occupancy;

  int checks = 0;
  int errors = 0;

  fp_vec_result_drain #(.EXP_BITS(5), .MANT_BITS(6), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
    in_valid = 1'b1; a_in = a; b_in = b; c_in = c; d_in = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    logic [3:0][W-1:0] v;
    v = {d, c, b, a};
    out_ready = 1'b1;
    for (int l = 0; l < 4; l++) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"},  32'(out_data),  32'(v[l]));
      chk({tag, "_lane"},  32'(out_lane),  32'(l));
      chk({tag, "_last"},  32'(out_last),  32'(l == 3));
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0][W-1:0] t1;
    issue = 0; in_valid = 0; out_ready = 0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;

    // reset values
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_lane",  32'(out_lane),  0);
    chk("rst_last",  32'(out_last),  0);
    chk("rst_occ",   32'(occupancy), 0);
    chk("rst_ovf",   32'(overflow),  0);
    chk("rst_iok",   32'(issue_ok),  1);
    step();
    rst = 1'b1;
    step();

    // single vector, 1-cycle latency, occupancy 1,1,1,1,0
    t1 = {12'h000, 12'hBC0, 12'h400, 12'h3C0};
    out_ready = 1'b1;
    push(12'h3C0, 12'h400, 12'hBC0, 12'h000);
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_data",  32'(out_data),  32'(t1[i]));
      chk("t1_lane",  32'(out_lane),  32'(i));
      chk("t1_last",  32'(out_last),  32'(i == 3));
      chk("t1_occ",   32'(occupancy), 1);
      step();
    end
    chk("t1_end_valid", 32'(out_valid), 0);
    chk("t1_end_data",  32'(out_data),  0);
    chk("t1_end_occ",   32'(occupancy), 0);

    // backpressure on lane b for 3 cycles
    push(12'h111, 12'h222, 12'h333, 12'h444);
    chk("bp_a", 32'(out_data), 32'h111);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data",  32'(out_data),  32'h222);
      chk("bp_hold_lane",  32'(out_lane),  1);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_last",  32'(out_last),  0);
      step();
    end
    out_ready = 1'b1;
    chk("bp_b", 32'(out_data), 32'h222);
    step();
    chk("bp_c", 32'(out_data), 32'h333);
    step();
    chk("bp_d",      32'(out_data), 32'h444);
    chk("bp_d_last", 32'(out_last), 1);
    step();
    chk("bp_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // credits
    for (int i = 0; i < 4; i++) begin
      chk("cr_iok_before", 32'(issue_ok), 1);
      issue = 1'b1; step(); issue = 1'b0;
    end
    chk("cr_iok_low", 32'(issue_ok), 0);
    chk("cr_ovf_0",   32'(overflow), 0);
    issue = 1'b1; step(); issue = 1'b0;
    chk("cr_ovf_5th", 32'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      push(12'h010 + 12'(i), 12'h020 + 12'(i), 12'h030 + 12'(i), 12'h040 + 12'(i));
      chk("cr_iok_ret", 32'(issue_ok), 0);
    end
    chk("cr_occ4", 32'(occupancy), 4);
    drain_vec("cr_v0", 12'h010, 12'h020, 12'h030, 12'h040);
    chk("cr_iok_back", 32'(issue_ok), 1);
    chk("cr_occ3",     32'(occupancy), 3);
    drain_vec("cr_v1", 12'h011, 12'h021, 12'h031, 12'h041);
    drain_vec("cr_v2", 12'h012, 12'h022, 12'h032, 12'h042);
    drain_vec("cr_v3", 12'h013, 12'h023, 12'h033, 12'h043);
    chk("cr_ovf_sticky", 32'(overflow), 1);
    #2 rst = 1'b0;
    #1 chk("cr_rst_ovf", 32'(overflow), 0);
    rst = 1'b1;
    step();

    // full with simultaneous write and pop
    push(12'hA00, 12'hA01, 12'hA02, 12'hA03);
    push(12'hA10, 12'hA11, 12'hA12, 12'hA13);
    push(12'hA20, 12'hA21, 12'hA22, 12'hA23);
    push(12'hA30, 12'hA31, 12'hA32, 12'hA33);
    chk("fp_occ4", 32'(occupancy), 4);
    chk("fp_iok",  32'(issue_ok),  0);
    out_ready = 1'b1;
    step(); step(); step();
    chk("fp_head_d",    32'(out_data), 32'hA03);
    chk("fp_head_last", 32'(out_last), 1);
    push(12'hE00, 12'hE01, 12'hE02, 12'hE03);
    out_ready = 1'b0;
    chk("fp_occ_kept", 32'(occupancy), 4);
    chk("fp_ovf",      32'(overflow),  0);
    drain_vec("fp_v1", 12'hA10, 12'hA11, 12'hA12, 12'hA13);
    drain_vec("fp_v2", 12'hA20, 12'hA21, 12'hA22, 12'hA23);
    drain_vec("fp_v3", 12'hA30, 12'hA31, 12'hA32, 12'hA33);
    drain_vec("fp_ve", 12'hE00, 12'hE01, 12'hE02, 12'hE03);
    chk("fp_empty", 32'(occupancy), 0);

    // overflow drop
    push(12'hB00, 12'hB01, 12'hB02, 12'hB03);
    push(12'hB10, 12'hB11, 12'hB12, 12'hB13);
    push(12'hB20, 12'hB21, 12'hB22, 12'hB23);
    push(12'hB30, 12'hB31, 12'hB32, 12'hB33);
    push(12'hFFF, 12'hFFE, 12'hFFD, 12'hFFC);
    chk("ov_set", 32'(overflow),  1);
    chk("ov_occ", 32'(occupancy), 4);
    step(); step();
    chk("ov_sticky", 32'(overflow), 1);
    drain_vec("ov_v0", 12'hB00, 12'hB01, 12'hB02, 12'hB03);
    drain_vec("ov_v1", 12'hB10, 12'hB11, 12'hB12, 12'hB13);
    drain_vec("ov_v2", 12'hB20, 12'hB21, 12'hB22, 12'hB23);
    drain_vec("ov_v3", 12'hB30, 12'hB31, 12'hB32, 12'hB33);
    chk("ov_empty",    32'(out_valid), 0);
    chk("ov_sticky2",  32'(overflow),  1);

    // async reset mid-vector
    push(12'hC00, 12'hC01, 12'hC02, 12'hC03);
    push(12'hC10, 12'hC11, 12'hC12, 12'hC13);
    out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    chk("ar_lane2", 32'(out_lane),  2);
    chk("ar_occ2",  32'(occupancy), 2);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_data",  32'(out_data),  0);
    chk("ar_lane",  32'(out_lane),  0);
    chk("ar_last",  32'(out_last),  0);
    chk("ar_occ",   32'(occupancy), 0);
    chk("ar_ovf",   32'(overflow),  0);
    chk("ar_iok",   32'(issue_ok),  1);
    #1 rst = 1'b1;
    step();
    chk("ar_post_valid", 32'(out_valid), 0);
    push(12'hD00, 12'hD01, 12'hD02, 12'hD03);
    chk("ar_post_iok", 32'(issue_ok), 1);
    drain_vec("ar_new", 12'hD00, 12'hD01, 12'hD02, 12'hD03);
    chk("ar_post_empty", 32'(occupancy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1);
  end
endmodule
